pll_freq_governor: RTL and testbench

- Run-time frequency governor for the hashing clock.
- Watches nonce-error, good-share and overheat indications over fixed observation windows, then raises or lowers the PLL multiplier within bounds.
- Hands each new multiplier to the PLL reconfiguration engine over a req/ack handshake, waits for PLL lock, and holds the hashers while the clock is unstable.
- Successor to the fixed-multiplier main clock PLL: frequency becomes a run-time variable instead of a build-time constant.

---
 rtl/pll_freq_governor.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_pll_freq_governor.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_freq_governor.sv
// pll_freq_governor
//   Run-time frequency governor for the hashing clock. Counts nonce errors and
//   good shares over fixed observation windows, reacts to thermal alarms, and
//   steps the PLL multiplier up or down within [MIN_MULT, MAX_MULT]. Each new
//   multiplier is handed to the PLL reconfiguration engine over a req/ack
//   handshake. The governor then waits for lock and lets the clock settle
//   before the hashers are released.
//
// Ports
//   osc_clk     governor clock (oscillator domain)
//   reset_n     asynchronous active-low reset
//   enable      1 = governor active, 0 = multiplier frozen (IDLE)
//   err_pulse   one-cycle pulse per nonce/hash error
//   good_pulse  one-cycle pulse per valid share
//   overheat    thermal alarm level
//   pll_locked  PLL lock indication (already synchronised)
//   cfg_ack     reconfiguration engine accepted cfg_mult
//   cfg_req     request to reprogram the PLL
//   cfg_mult    multiplier to program, stable while cfg_req=1
//   cur_mult    multiplier currently in effect
//   hash_hold   1 = hashers must stall
//   fault       sticky: lock lost or never achieved
//   state_dbg   encoded FSM state
module pll_freq_governor #(
  parameter int MULT_W       = 8,
  parameter int START_MULT   = 20,
  parameter int MIN_MULT     = 10,
  parameter int MAX_MULT     = 40,
  parameter int STEP         = 1,
  parameter int WINDOW       = 50000000,
  parameter int ERR_LIMIT    = 2,
  parameter int LOCK_TIMEOUT = 1000000,
  parameter int SETTLE       = 1024
) (
  input  logic              osc_clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              err_pulse,
  input  logic              good_pulse,
  input  logic              overheat,
  input  logic              pll_locked,
  input  logic              cfg_ack,
  output logic              cfg_req,
  output logic [MULT_W-1:0] cfg_mult,
  output logic [MULT_W-1:0] cur_mult,
  output logic              hash_hold,
  output logic              fault,
  output logic [2:0]        state_dbg
);

  // The window counter is nominally 24 bits; it widens only when WINDOW
  // would not fit.
  localparam int WIN_W = ($clog2(WINDOW) > 24) ? $clog2(WINDOW) : 24;
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int EXT_W = MULT_W + 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RUN      = 3'd1;
  localparam logic [2:0] ST_REQ      = 3'd2;
  localparam logic [2:0] ST_LOCKWAIT = 3'd3;
  localparam logic [2:0] ST_SETTLE   = 3'd4;
  localparam logic [2:0] ST_FAULT    = 3'd5;

  // Lower the multiplier by amt, clamped at MIN_MULT. The extra bit keeps the
  // comparison free of wrap-around.
  function automatic logic [MULT_W-1:0] step_down(input logic [MULT_W-1:0] cur,
                                                  input logic [EXT_W-1:0]  amt);
    logic [EXT_W-1:0] cur_x;
    cur_x = {1'b0, cur};
    if (cur_x < (EXT_W'(MIN_MULT) + amt)) begin
      step_down = MULT_W'(MIN_MULT);
    end else begin
      step_down = MULT_W'(cur_x - amt);
    end
  endfunction

  // Raise the multiplier by amt, clamped at MAX_MULT. The sum is formed one
  // bit wider so that it cannot overflow.
  function automatic logic [MULT_W-1:0] step_up(input logic [MULT_W-1:0] cur,
                                                input logic [EXT_W-1:0]  amt);
    logic [EXT_W-1:0] sum_x;
    sum_x = {1'b0, cur} + amt;
    if (sum_x > EXT_W'(MAX_MULT)) begin
      step_up = MULT_W'(MAX_MULT);
    end else begin
      step_up = MULT_W'(sum_x);
    end
  endfunction

  // 8-bit saturating increment.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 8'd1;
    end
  endfunction

  logic [2:0]        state_r, state_nxt_s;
  logic [WIN_W-1:0]  win_cnt_r, win_nxt_s;
  logic [7:0]        err_cnt_r, err_nxt_s;
  logic [7:0]        good_cnt_r, good_nxt_s;
  logic [TMO_W-1:0]  tmo_cnt_r, tmo_nxt_s;
  logic [SET_W-1:0]  set_cnt_r, set_nxt_s;
  logic              retry_r, retry_nxt_s;
  logic              cfg_req_r, cfg_req_nxt_s;
  logic [MULT_W-1:0] cfg_mult_r, cfg_mult_nxt_s;
  logic [MULT_W-1:0] cur_mult_r, cur_mult_nxt_s;
  logic              hash_hold_r, hash_hold_nxt_s;
  logic              fault_r, fault_nxt_s;

  logic [7:0]        err_acc_s, good_acc_s;
  logic              decide_s;
  logic [MULT_W-1:0] target_s;

  // Window decision: counts include any pulse on the deciding cycle itself,
  // and overheat overrides the window end.
  always_comb begin
    if (err_pulse) begin
      err_acc_s = sat_inc(err_cnt_r);
    end else begin
      err_acc_s = err_cnt_r;
    end
    if (good_pulse) begin
      good_acc_s = sat_inc(good_cnt_r);
    end else begin
      good_acc_s = good_cnt_r;
    end
    decide_s = 1'b0;
    target_s = cur_mult_r;
    if (overheat) begin
      decide_s = 1'b1;
      target_s = step_down(cur_mult_r, EXT_W'(2 * STEP));
    end else if (win_cnt_r == WIN_W'(WINDOW - 1)) begin
      decide_s = 1'b1;
      if (err_acc_s > 8'(ERR_LIMIT)) begin
        target_s = step_down(cur_mult_r, EXT_W'(STEP));
      end else if ((err_acc_s == 8'd0) && (good_acc_s != 8'd0)) begin
        target_s = step_up(cur_mult_r, EXT_W'(STEP));
      end else begin
        target_s = cur_mult_r;
      end
    end else begin
      decide_s = 1'b0;
      target_s = cur_mult_r;
    end
  end

  // Next-state and next-output logic for the governor FSM.
  always_comb begin
    state_nxt_s     = state_r;
    win_nxt_s       = win_cnt_r;
    err_nxt_s       = err_cnt_r;
    good_nxt_s      = good_cnt_r;
    tmo_nxt_s       = tmo_cnt_r;
    set_nxt_s       = set_cnt_r;
    retry_nxt_s     = retry_r;
    cfg_req_nxt_s   = cfg_req_r;
    cfg_mult_nxt_s  = cfg_mult_r;
    cur_mult_nxt_s  = cur_mult_r;
    hash_hold_nxt_s = hash_hold_r;
    fault_nxt_s     = fault_r;
    case (state_r)
      ST_IDLE: begin
        win_nxt_s     = '0;
        err_nxt_s     = 8'd0;
        good_nxt_s    = 8'd0;
        cfg_req_nxt_s = 1'b0;
        if (!pll_locked) begin
          state_nxt_s     = ST_LOCKWAIT;
          fault_nxt_s     = 1'b1;
          hash_hold_nxt_s = 1'b1;
          tmo_nxt_s       = '0;
        end else if (enable) begin
          state_nxt_s     = ST_RUN;
          hash_hold_nxt_s = 1'b0;
        end else begin
          state_nxt_s     = ST_IDLE;
          hash_hold_nxt_s = 1'b0;
        end
      end
      ST_RUN: begin
        cfg_req_nxt_s = 1'b0;
        if (!pll_locked) begin
          state_nxt_s     = ST_LOCKWAIT;
          fault_nxt_s     = 1'b1;
          hash_hold_nxt_s = 1'b1;
          tmo_nxt_s       = '0;
        end else if (!enable) begin
          state_nxt_s     = ST_IDLE;
          hash_hold_nxt_s = 1'b0;
          win_nxt_s       = '0;
          err_nxt_s       = 8'd0;
          good_nxt_s      = 8'd0;
        end else if (decide_s) begin
          win_nxt_s  = '0;
          err_nxt_s  = 8'd0;
          good_nxt_s = 8'd0;
          // No request when the target equals the current value (e.g. at a bound).
          if (target_s != cur_mult_r) begin
            cfg_mult_nxt_s  = target_s;
            cfg_req_nxt_s   = 1'b1;
            hash_hold_nxt_s = 1'b1;
            state_nxt_s     = ST_REQ;
          end else begin
            hash_hold_nxt_s = 1'b0;
            state_nxt_s     = ST_RUN;
          end
        end else begin
          win_nxt_s       = win_cnt_r + WIN_W'(1);
          err_nxt_s       = err_acc_s;
          good_nxt_s      = good_acc_s;
          hash_hold_nxt_s = 1'b0;
        end
      end
      ST_REQ: begin
        hash_hold_nxt_s = 1'b1;
        if (cfg_ack) begin
          cfg_req_nxt_s  = 1'b0;
          cur_mult_nxt_s = cfg_mult_r;
          tmo_nxt_s      = '0;
          state_nxt_s    = ST_LOCKWAIT;
        end else begin
          cfg_req_nxt_s = 1'b1;
        end
      end
      ST_LOCKWAIT: begin
        hash_hold_nxt_s = 1'b1;
        cfg_req_nxt_s   = 1'b0;
        if (pll_locked) begin
          set_nxt_s   = '0;
          state_nxt_s = ST_SETTLE;
        end else if (tmo_cnt_r == TMO_W'(LOCK_TIMEOUT - 1)) begin
          // The first timeout retries once at the safe multiplier; a second
          // consecutive timeout is terminal.
          if (retry_r) begin
            state_nxt_s = ST_FAULT;
          end else begin
            retry_nxt_s    = 1'b1;
            fault_nxt_s    = 1'b1;
            cfg_mult_nxt_s = MULT_W'(MIN_MULT);
            cfg_req_nxt_s  = 1'b1;
            state_nxt_s    = ST_REQ;
          end
        end else begin
          tmo_nxt_s = tmo_cnt_r + TMO_W'(1);
        end
      end
      ST_SETTLE: begin
        hash_hold_nxt_s = 1'b1;
        cfg_req_nxt_s   = 1'b0;
        if (!pll_locked) begin
          tmo_nxt_s   = '0;
          state_nxt_s = ST_LOCKWAIT;
        end else if (set_cnt_r == SET_W'(SETTLE - 1)) begin
          retry_nxt_s     = 1'b0;
          win_nxt_s       = '0;
          err_nxt_s       = 8'd0;
          good_nxt_s      = 8'd0;
          set_nxt_s       = '0;
          tmo_nxt_s       = '0;
          hash_hold_nxt_s = 1'b0;
          if (enable) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          set_nxt_s = set_cnt_r + SET_W'(1);
        end
      end
      ST_FAULT: begin
        hash_hold_nxt_s = 1'b1;
        cfg_req_nxt_s   = 1'b0;
      end
      default: begin
        state_nxt_s     = ST_FAULT;
        hash_hold_nxt_s = 1'b1;
        cfg_req_nxt_s   = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_LOCKWAIT;
      win_cnt_r   <= '0;
      err_cnt_r   <= 8'd0;
      good_cnt_r  <= 8'd0;
      tmo_cnt_r   <= '0;
      set_cnt_r   <= '0;
      retry_r     <= 1'b0;
      cfg_req_r   <= 1'b0;
      cfg_mult_r  <= MULT_W'(START_MULT);
      cur_mult_r  <= MULT_W'(START_MULT);
      hash_hold_r <= 1'b1;
      fault_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      win_cnt_r   <= win_nxt_s;
      err_cnt_r   <= err_nxt_s;
      good_cnt_r  <= good_nxt_s;
      tmo_cnt_r   <= tmo_nxt_s;
      set_cnt_r   <= set_nxt_s;
      retry_r     <= retry_nxt_s;
      cfg_req_r   <= cfg_req_nxt_s;
      cfg_mult_r  <= cfg_mult_nxt_s;
      cur_mult_r  <= cur_mult_nxt_s;
      hash_hold_r <= hash_hold_nxt_s;
      fault_r     <= fault_nxt_s;
    end
  end

  assign cfg_req   = cfg_req_r;
  assign cfg_mult  = cfg_mult_r;
  assign cur_mult  = cur_mult_r;
  assign hash_hold = hash_hold_r;
  assign fault     = fault_r;
  assign state_dbg = state_r;

endmodule

// File: tb/tb_pll_freq_governor.sv
// Testbench for pll_freq_governor. Randomised observation windows are driven
// while a behavioural model decides the expected multiplier for each window.
// Every expected request value goes into a queue that a separate monitor
// drains whenever cfg_req rises.
module tb_pll_freq_governor;
  localparam int START     = 20;
  localparam int MINM      = 10;
  localparam int MAXM      = 40;
  localparam int STEP      = 1;
  localparam int WINDOW    = 100;
  localparam int ERR_LIMIT = 2;
  localparam int LT        = 40;
  localparam int SETTLE    = 16;

  logic       osc_clk = 1'b0;
  logic       reset_n, enable, err_pulse, good_pulse, overheat, pll_locked, cfg_ack;
  logic       cfg_req, hash_hold, fault;
  logic [7:0] cfg_mult, cur_mult;
  logic [2:0] state_dbg;

  pll_freq_governor #(
    .MULT_W(8), .START_MULT(START), .MIN_MULT(MINM), .MAX_MULT(MAXM), .STEP(STEP),
    .WINDOW(WINDOW), .ERR_LIMIT(ERR_LIMIT), .LOCK_TIMEOUT(LT), .SETTLE(SETTLE)
  ) dut (
    .osc_clk(osc_clk), .reset_n(reset_n), .enable(enable), .err_pulse(err_pulse),
    .good_pulse(good_pulse), .overheat(overheat), .pll_locked(pll_locked),
    .cfg_ack(cfg_ack), .cfg_req(cfg_req), .cfg_mult(cfg_mult), .cur_mult(cur_mult),
    .hash_hold(hash_hold), .fault(fault), .state_dbg(state_dbg)
  );

  always #5 osc_clk = ~osc_clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  int         model_cur;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare each new request with the scoreboard and check that
  // cfg_mult stays stable while the request is held.
  logic       req_q = 1'b0;
  logic [7:0] held_mult = 8'd0;
  always @(negedge osc_clk) begin
    if (cfg_req && !req_q) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_req: got cfg_mult %0d, expected no request", cfg_mult);
      end else begin
        chk("req_mult", cfg_mult, exp_q.pop_front());
      end
      held_mult <= cfg_mult;
    end else if (cfg_req && req_q) begin
      chk("mult_stable", cfg_mult, held_mult);
    end
    req_q <= cfg_req;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge osc_clk);
  endtask

  // Raise lock, then count the cycles hash_hold stays high.
  task automatic lock_up(input int dly, input string name);
    int cnt;
    tick(dly);
    pll_locked = 1'b1;
    cnt = 0;
    @(negedge osc_clk);
    while (hash_hold && cnt < SETTLE + 50) begin
      cnt++;
      @(negedge osc_clk);
    end
    chk(name, cnt, SETTLE);
    chk("run_state", state_dbg, 1);
  endtask

  // One observation window starting at the next posedge. The reference model
  // counts the pulses that were actually driven and applies the window rules.
  task automatic do_window(input int n_err, input int n_good, input int oh_cyc,
                           input bit coinc, output bit req, output int tgt);
    bit e_at[WINDOW];
    bit g_at[WINDOW];
    int last, e, g, slot;
    for (int k = 0; k < WINDOW; k++) begin
      e_at[k] = 1'b0;
      g_at[k] = 1'b0;
    end
    if (n_err > 0) begin
      slot = WINDOW / n_err;
      for (int j = 0; j < n_err; j++) begin
        e_at[j * slot + int'($urandom_range(0, slot - 1))] = 1'b1;
      end
    end
    if (n_good > 0) begin
      slot = WINDOW / n_good;
      for (int j = 0; j < n_good; j++) begin
        g_at[j * slot + int'($urandom_range(0, slot - 1))] = 1'b1;
      end
    end
    if (coinc) begin
      for (int k = 0; k < WINDOW; k++) g_at[k] = e_at[k];
    end
    last = (oh_cyc >= 0) ? oh_cyc : WINDOW - 1;
    e = 0;
    g = 0;
    for (int k = 0; k <= last; k++) begin
      e += int'(e_at[k]);
      g += int'(g_at[k]);
    end
    if (oh_cyc >= 0) begin
      tgt = (model_cur - 2 * STEP < MINM) ? MINM : model_cur - 2 * STEP;
    end else if (e > ERR_LIMIT) begin
      tgt = (model_cur - STEP < MINM) ? MINM : model_cur - STEP;
    end else if (e == 0 && g > 0) begin
      tgt = (model_cur + STEP > MAXM) ? MAXM : model_cur + STEP;
    end else begin
      tgt = model_cur;
    end
    req = (tgt != model_cur);
    if (req) exp_q.push_back(8'(tgt));
    for (int k = 0; k <= last; k++) begin
      err_pulse  = e_at[k];
      good_pulse = g_at[k];
      overheat   = (k == oh_cyc);
      @(negedge osc_clk);
    end
    err_pulse  = 1'b0;
    good_pulse = 1'b0;
    overheat   = 1'b0;
  endtask

  // Acknowledge a request, let the PLL relock, and check the new multiplier.
  task automatic handshake(input int tgt);
    int n;
    n = 0;
    while (!cfg_req && n < 20) begin
      n++;
      @(negedge osc_clk);
    end
    chk("req_latency", n, 0);
    chk("hold_in_req", hash_hold, 1);
    tick(int'($urandom_range(0, 3)));
    cfg_ack    = 1'b1;
    pll_locked = 1'b0;
    @(negedge osc_clk);
    cfg_ack = 1'b0;
    chk("req_drop", cfg_req, 0);
    chk("cur_mult", cur_mult, tgt);
    model_cur = tgt;
    lock_up(int'($urandom_range(1, 5)), "settle_len");
  endtask

  task automatic window_step(input int n_err, input int n_good, input int oh_cyc, input bit coinc);
    bit req;
    int tgt;
    do_window(n_err, n_good, oh_cyc, coinc, req, tgt);
    if (req) begin
      handshake(tgt);
    end else begin
      chk("no_req", cfg_req, 0);
      chk("cur_hold", cur_mult, model_cur);
    end
  endtask

  initial begin : stim
    bit req;
    int tgt, n, oh, guard;
    reset_n = 1'b0; enable = 1'b1; err_pulse = 1'b0; good_pulse = 1'b0;
    overheat = 1'b0; pll_locked = 1'b0; cfg_ack = 1'b0;
    model_cur = START;
    tick(3);
    chk("rst_cur_mult", cur_mult, START);
    chk("rst_cfg_mult", cfg_mult, START);
    chk("rst_cfg_req", cfg_req, 0);
    chk("rst_hash_hold", hash_hold, 1);
    chk("rst_fault", fault, 0);
    chk("rst_state", state_dbg, 3);
    reset_n = 1'b1;
    tick(2);
    lock_up(3, "startup_settle");

    // Clean window with shares goes up; errors step down; a window with at
    // most ERR_LIMIT errors holds and leaves clean counters behind.
    window_step(0, 1, -1, 1'b0);
    window_step(3, 2, -1, 1'b0);
    window_step(3, 0, -1, 1'b0);
    window_step(2, 3, -1, 1'b0);
    window_step(1, 2, -1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      oh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WINDOW - 2)) : -1;
      window_step(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), oh, 1'b0);
    end

    // Disable: IDLE releases the hashers and freezes the multiplier.
    enable = 1'b0;
    @(negedge osc_clk);
    chk("idle_state", state_dbg, 0);
    chk("idle_hold", hash_hold, 0);
    tick(5);
    enable = 1'b1;
    @(negedge osc_clk);
    chk("resume_state", state_dbg, 1);
    window_step(0, 1, -1, 1'b0);

    // Walk down to MIN_MULT with overheat, passing through 11 -> 10 clamped.
    if (model_cur > MINM && ((model_cur - MINM) % 2) == 0) window_step(3, 0, -1, 1'b0);
    guard = 0;
    while (model_cur > MINM && guard < 30) begin
      guard++;
      window_step(0, 0, int'($urandom_range(5, 60)), 1'b0);
    end
    chk("at_min", cur_mult, MINM);
    window_step(0, 1, 30, 1'b0);

    // Walk up to MAX_MULT, then a clean window at the bound issues nothing.
    guard = 0;
    while (model_cur < MAXM && guard < 40) begin
      guard++;
      window_step(0, int'($urandom_range(1, 3)), -1, 1'b0);
    end
    chk("at_max", cur_mult, MAXM);
    window_step(0, 2, -1, 1'b0);
    window_step(1, 1, -1, 1'b1);
    window_step(3, 3, -1, 1'b1);

    // Lock never arrives: one retry at MIN_MULT with fault set, then FAULT.
    do_window(3, 0, -1, 1'b0, req, tgt);
    chk("to_req", cfg_req, 1);
    cfg_ack    = 1'b1;
    pll_locked = 1'b0;
    @(negedge osc_clk);
    cfg_ack = 1'b0;
    chk("fault_before_timeout", fault, 0);
    exp_q.push_back(8'(MINM));
    n = 0;
    while (!cfg_req && n < LT + 20) begin
      n++;
      @(negedge osc_clk);
    end
    chk("timeout_len", n, LT);
    chk("fault_after_timeout", fault, 1);
    chk("hold_in_retry", hash_hold, 1);
    cfg_ack = 1'b1;
    @(negedge osc_clk);
    cfg_ack = 1'b0;
    chk("retry_cur_mult", cur_mult, MINM);
    n = 0;
    while (state_dbg != 3'd5 && n < LT + 20) begin
      n++;
      @(negedge osc_clk);
    end
    chk("fault_state_len", n, LT);
    pll_locked = 1'b1;
    tick(SETTLE + 5);
    chk("fault_terminal", state_dbg, 5);
    chk("fault_hold", hash_hold, 1);
    chk("fault_no_req", cfg_req, 0);
    chk("fault_sticky", fault, 1);

    // Reset while a request is pending drops cfg_req without a clock edge.
    reset_n = 1'b0;
    pll_locked = 1'b0;
    tick(2);
    reset_n = 1'b1;
    model_cur = START;
    tick(2);
    lock_up(2, "settle_after_reset");
    chk("fault_cleared", fault, 0);
    do_window(0, 2, -1, 1'b0, req, tgt);
    chk("req_before_reset", cfg_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_req_drop", cfg_req, 0);
    chk("async_cur_mult", cur_mult, START);
    chk("async_state", state_dbg, 3);
    chk("async_hold", hash_hold, 1);
    chk("async_fault", fault, 0);
    @(negedge osc_clk);
    pll_locked = 1'b0;
    reset_n = 1'b1;
    tick(2);
    lock_up(2, "settle_after_reset2");

    // Lock lost while running: fault, hold, back to LOCKWAIT.
    tick(int'($urandom_range(5, 50)));
    pll_locked = 1'b0;
    @(negedge osc_clk);
    chk("loss_fault", fault, 1);
    chk("loss_hold", hash_hold, 1);
    chk("loss_state", state_dbg, 3);
    tick(3);
    lock_up(1, "settle_after_loss");
    window_step(0, 1, -1, 1'b0);
    chk("fault_stays", fault, 1);

    tick(2);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
